// File: rtl/popcount_arbiter.sv
// popcount_arbiter: round-robin sharing of one 32-bit popcount datapath among
// NREQ valid/ready requesters, with a two-stage (operand, response) pipeline.
// Optional feature: define POPCOUNT_ARB_STALL_CNT_EN to add a saturating
// 16-bit stall_cnt output counting cycles with rsp_valid & !rsp_ready.
module popcount_arbiter #(
    parameter  int unsigned NREQ = 4,
    localparam int unsigned IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [32*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [5:0]           rsp_count
`ifdef POPCOUNT_ARB_STALL_CNT_EN
    ,
    output logic [15:0]          stall_cnt
`endif
);

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 6;
    localparam int unsigned SW = IDW + 1;

    // operand stage
    logic            op_valid;
    logic [IDW-1:0]  op_id;
    logic [DW-1:0]   op_data;

    // round-robin pointer: index of the most recent winner
    logic [IDW-1:0]  ptr;

    logic            rsp_adv;
    logic            op_adv;
    logic            accept;

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_id;
    logic            grant_found;
    logic [SW-1:0]   cand;
    logic [DW-1:0]   grant_word;
    logic [CW-1:0]   op_count;

    assign rsp_adv = !rsp_valid || rsp_ready;
    assign op_adv  = !op_valid || rsp_adv;

    // Round-robin scan starting just after the previous winner, wrapping modulo NREQ.
    always_comb begin
        grant       = '0;
        grant_id    = '0;
        grant_found = 1'b0;
        cand        = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = SW'(ptr) + SW'(k);
            if (cand >= SW'(NREQ)) begin
                cand = cand - SW'(NREQ);
            end
            if (!grant_found && req_valid[IDW'(cand)]) begin
                grant_found          = 1'b1;
                grant_id             = IDW'(cand);
                grant[IDW'(cand)]    = 1'b1;
            end
        end
    end

    // Handshake: grant only when the operand stage can take a word; silent in reset.
    assign req_ready = grant & {NREQ{op_adv & rst_n}};
    assign accept    = |req_ready;

    // AND-OR select of the granted requester's word.
    always_comb begin
        grant_word = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            grant_word = grant_word | (req_data[DW*i +: DW] & {DW{grant[i]}});
        end
    end

    // Population count of the operand word; 32 fits in 6 bits without overflow.
    always_comb begin
        op_count = '0;
        for (int unsigned i = 0; i < DW; i++) begin
            op_count = op_count + CW'(op_data[i]);
        end
    end

    // Operand stage and arbitration pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_valid <= 1'b0;
            op_id    <= '0;
            op_data  <= '0;
            ptr      <= IDW'(NREQ - 1);
        end else if (op_adv) begin
            if (accept) begin
                op_valid <= 1'b1;
                op_id    <= grant_id;
                op_data  <= grant_word;
                ptr      <= grant_id;
            end else begin
                op_valid <= 1'b0;
            end
        end
    end

    // Response stage: holds steady under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_count <= '0;
        end else if (rsp_adv) begin
            rsp_valid <= op_valid;
            rsp_id    <= op_id;
            rsp_count <= op_count;
        end
    end

`ifdef POPCOUNT_ARB_STALL_CNT_EN
    // Saturating count of cycles where a response waits on the consumer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (rsp_valid && !rsp_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule
